// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register: DEPTH stages of payload plus control bundle,
// bubble-collapsing stall, synchronous flush and an optional skid buffer that registers in_ready.
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int SKID   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [2:0]        occupancy
);

  localparam bit HAS_SKID = (SKID != 32'sd0);

  logic [DEPTH-1:0]  v_r;
  logic [DEPTH-1:0]  adv_s;
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [CTRL_W-1:0] ctrl_r [DEPTH];

  logic              skid_v_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;

  logic              src_v_s;
  logic [DATA_W-1:0] src_data_s;
  logic [CTRL_W-1:0] src_ctrl_s;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic [2:0]        occ_r;

  // Advance chain: a stage moves when it is empty or the stage above moves.
  always_comb begin : adv_chain
    logic nxt;
    adv_s = '0;
    nxt   = !v_r[DEPTH-1] || out_ready;
    adv_s[DEPTH-1] = nxt;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      nxt      = !v_r[i] || nxt;
      adv_s[i] = nxt;
    end
  end

  assign in_ready   = HAS_SKID ? !skid_v_r : adv_s[0];
  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = v_r[DEPTH-1] && out_ready;

  // Stage 0 source: a parked skid beat has priority over the live input.
  always_comb begin
    src_v_s    = 1'b0;
    src_data_s = in_data;
    src_ctrl_s = in_ctrl;
    if (HAS_SKID && skid_v_r) begin
      src_v_s    = 1'b1;
      src_data_s = skid_data_r;
      src_ctrl_s = skid_ctrl_r;
    end else begin
      src_v_s    = in_xfer_s;
      src_data_s = in_data;
      src_ctrl_s = in_ctrl;
    end
  end

  // Stage registers; ctrl is reloaded with zero on every bubble so an empty output stage drives 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= '0;
        ctrl_r[i] <= '0;
      end
    end else if (flush) begin
      v_r              <= '0;
      data_r[DEPTH-1]  <= '0;
      ctrl_r[DEPTH-1]  <= '0;
    end else begin
      if (adv_s[0]) begin
        v_r[0]    <= src_v_s;
        ctrl_r[0] <= src_v_s ? src_ctrl_s : '0;
        if (src_v_s) begin
          data_r[0] <= src_data_s;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv_s[i]) begin
          v_r[i]    <= v_r[i-1];
          ctrl_r[i] <= v_r[i-1] ? ctrl_r[i-1] : '0;
          if (v_r[i-1]) begin
            data_r[i] <= data_r[i-1];
          end
        end
      end
    end
  end

  // Skid entry: catches the beat accepted while stage 0 is stalled, drains when stage 0 moves.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      skid_v_r    <= 1'b0;
      skid_data_r <= '0;
      skid_ctrl_r <= '0;
    end else if (flush) begin
      skid_v_r <= 1'b0;
    end else if (HAS_SKID) begin
      if (skid_v_r && adv_s[0]) begin
        skid_v_r <= 1'b0;
      end else if (in_xfer_s && !adv_s[0]) begin
        skid_v_r    <= 1'b1;
        skid_data_r <= in_data;
        skid_ctrl_r <= in_ctrl;
      end
    end
  end

  // Occupancy counter tracks accepted-minus-delivered beats.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ_r <= 3'd0;
    end else if (flush) begin
      occ_r <= 3'd0;
    end else begin
      case ({in_xfer_s, out_xfer_s})
        2'b10:   occ_r <= occ_r + 3'd1;
        2'b01:   occ_r <= occ_r - 3'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign out_valid = v_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];
  assign out_ctrl  = ctrl_r[DEPTH-1];
  assign occupancy = occ_r;

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed MEM/WB-style pipeline register.
- Moves a DATA_W payload plus a CTRL_W control bundle (RegWrite, MemWrite, peripheral selects and similar) through DEPTH register stages.
- Uses a valid/ready handshake, per-stage stall and a synchronous flush.
- An optional skid buffer registers in_ready, so there is no combinational ready path back into the upstream stage.

Parameters:
- DATA_W, 32, payload width.
- CTRL_W, 8, control bundle width; each bit is qualified by valid.
- DEPTH, 1, number of pipeline stages; legal range 1..4.
- SKID, 1, 1 = insert a one-entry skid buffer and register in_ready; 0 = in_ready is combinational.

Ports:
- CLK input 1 system clock; rising edge.
- RST input 1 asynchronous, active-high reset.
- in_valid input 1 upstream has a beat.
- in_ready output 1 block accepts a beat this cycle.
- in_data input DATA_W upstream payload.
- in_ctrl input CTRL_W upstream control bundle.
- flush input 1 synchronous kill of all in-flight beats.
- out_valid output 1 last stage holds a valid beat.
- out_ready input 1 downstream accepts.
- out_data output DATA_W payload of the last stage.
- out_ctrl output CTRL_W control of the last stage; forced to 0 when out_valid = 0.
- occupancy output 3 number of valid entries, stages plus skid; range 0..DEPTH+SKID.

Behaviour:
- Reset (RST=1, asynchronous):
  - All stage valids, skid valid, data and ctrl registers clear to 0.
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - in_ready=1 when SKID=1. When SKID=0, in_ready follows the combinational rule below (evaluates to 1).
  - Reset mid-transfer discards all beats; no partial output.
- Handshake:
  - A transfer occurs on a rising edge with valid&&ready on that interface.
  - in_data and in_ctrl are sampled only on an in transfer.
  - out_* hold stable while out_valid && !out_ready.
- Stage advance, stage i = 0..DEPTH-1 with stage DEPTH-1 as output:
  - adv[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - adv[i] = !v[i] || adv[i+1].
  - Bubbles collapse: an empty stage always accepts from below.
- SKID=0: in_ready = adv[0], combinational from out_ready.
- SKID=1:
  - in_ready = !skid_v, registered.
  - If in_valid && in_ready && !adv[0], the beat is written into skid and skid_v is set; in_ready is 0 next cycle.
  - Stage 0 load source: skid when skid_v, otherwise the input. Skid has priority.
  - Skid empties when adv[0]=1. in_ready rises the following cycle.
  - Only one beat is ever held in skid.
- Latency and throughput:
  - Accept to out_valid is DEPTH cycles with no backpressure.
  - Sustained throughput is 1 beat/cycle when out_ready is held 1, for both SKID values.
- Ctrl qualification: out_ctrl = v[DEPTH-1] ? ctrl[DEPTH-1] : 0. A bubble can never assert RegWrite or MemWrite downstream.
- Data registers of invalid stages may hold stale values. The exception is out_data, which is zeroed when its stage is cleared by flush or reset.
- Flush (synchronous, highest priority):
  - On the edge with flush=1, all v[] and skid_v clear.
  - out_ctrl and out_data are 0 the next cycle.
  - A beat presented with in_valid on the flush cycle is dropped, even if in_ready=1.
  - An out transfer on the flush cycle still completes (downstream saw valid&&ready).
  - in_ready=1 the cycle after flush.
- Occupancy:
  - Registered count, updated each edge as +1 on an in transfer and -1 on an out transfer.
  - Set to 0 on flush or reset.
  - Never exceeds DEPTH+SKID and never underflows.
- Simultaneous in and out transfer on a full pipe: occupancy is unchanged and the data shift is lossless.

Test Plan:
- Reset release, DEPTH=2, SKID=1: drive in_data=0x11..0x15 on consecutive cycles with out_ready=1.
  - Required: out_data 0x11..0x15 appear on cycles 2..6 with no gaps.
  - Required: occupancy settles at 2; out_ctrl equals in_ctrl of each beat.
- Backpressure, DEPTH=2, SKID=1: stream beats A..E, drop out_ready for 3 cycles, then reraise it.
  - Required: in_ready drops exactly one cycle after the skid fills; occupancy peaks at 3.
  - Required: A..E delivered in order, none lost or duplicated.
- Bubble ctrl, in_ctrl=8'hFF: send one beat, then hold in_valid=0.
  - Required: out_ctrl=8'hFF only on the valid cycle and 8'h00 on every other cycle.
- Flush, DEPTH=3, pipe full, in_valid=1 with beat X: assert flush for one cycle.
  - Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
  - Required: beat X never appears at the output.
- Asynchronous reset mid-stream: pulse RST between clock edges while occupancy=2.
  - Required: out_valid=0 and out_ctrl=0 immediately, without waiting for a clock edge.
  - Required: the stream resumes correctly after release.
- SKID=0, DEPTH=1: toggle out_ready every cycle.
  - Required: in_ready equals !out_valid||out_ready in the same cycle.
  - Required: throughput is 50%, with no loss.
